// File: rtl/run_detect_ctrl.sv
// run_detect_ctrl: serial run-length detector with IDLE/RUN/DONE session control.
// Counts runs of a selectable bit value, flags each match on z and stops at a hit limit.
module run_detect_ctrl #(
    parameter int CNT_W = 8,
    parameter int LEN_W = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic             ack,
    input  logic             w,
    input  logic [1:0]       mode,
    input  logic [LEN_W-1:0] run_len,
    input  logic [CNT_W-1:0] hit_limit,
    output logic             busy,
    output logic             z,
    output logic [CNT_W-1:0] hit_count,
    output logic             done,
    output logic [1:0]       state
);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    logic [1:0]       mode_q;
    logic [LEN_W-1:0] len_q, run_cnt, len_eff, cnt_nxt;
    logic [CNT_W-1:0] lim_q, hit_inc;
    logic             prev, permit, match, at_limit;

    // run_cnt==0 marks the first sample of a session, so no separate flag is kept
    always_comb begin
        len_eff  = (len_q == '0) ? LEN_W'(1) : len_q;
        cnt_nxt  = (run_cnt == '0 || w != prev) ? LEN_W'(1) :
                   (run_cnt >= len_eff) ? run_cnt : run_cnt + LEN_W'(1);
        permit   = mode_q[1] | (w == mode_q[0]);
        match    = (cnt_nxt == len_eff) && permit;
        hit_inc  = (&hit_count) ? hit_count : hit_count + CNT_W'(1);
        at_limit = (lim_q != '0) && (hit_inc == lim_q);
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            z         <= 1'b0;
            hit_count <= '0;
            run_cnt   <= '0;
            prev      <= 1'b0;
            mode_q    <= '0;
            len_q     <= '0;
            lim_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    z <= 1'b0;
                    if (start) begin
                        mode_q    <= mode;
                        len_q     <= run_len;
                        lim_q     <= hit_limit;
                        hit_count <= '0;
                        run_cnt   <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        z     <= 1'b0;
                        state <= IDLE;
                    end else begin
                        run_cnt <= cnt_nxt;
                        prev    <= w;
                        z       <= match;
                        if (match) begin
                            hit_count <= hit_inc;
                            if (at_limit) state <= DONE;
                        end
                    end
                end
                DONE: begin
                    z <= 1'b0;
                    if (ack) state <= IDLE;
                end
                default: begin
                    z     <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
